pipein_frame_assembler: RTL and testbench
=========================================

Name: pipein_frame_assembler

Overview:
- Upstream stage of the adder-tree reduction FSM.
- Packs 32-bit pipe-in words (okPipeIn 0x80 ep_dataout/ep_write) into 128-bit frames and presents each frame with a valid/ready handshake to the consumer.
- Double-buffered: one frame fills while the previous one waits for the consumer's start.
- Replaces the inline index/store logic in the top level. Adds overflow detection, flush, and status.

Parameters:
- WORD_W, 32, input word width.
- WORDS_PER_FRAME, 4, words per frame; must be >= 2.
- FRAME_W, WORD_W*WORDS_PER_FRAME (128), frame width; derived, not overridable.
- LVL_W, $clog2(WORDS_PER_FRAME+1) (3), width of fill_level.

Ports:
- okClk  in  1  clock; all logic on the rising edge.
- rstn  in  1  reset, synchronous, active-low.
- in_data  in  WORD_W  pipe-in word.
- in_valid  in  1  word strobe, one word per cycle.
- flush  in  1  discard the partial fill buffer.
- clr_overflow  in  1  clear the overflow flag and drop_cnt.
- frame_ready  in  1  consumer accepts the frame (driven from the trigger-in start).
- frame_data  out  FRAME_W  held frame.
- frame_valid  out  1  held frame available.
- fill_level  out  LVL_W  words currently in the fill buffer (0..WORDS_PER_FRAME).
- overflow  out  1  sticky: at least one word was dropped.
- drop_cnt  out  16  number of dropped words, saturating at 0xFFFF.

Behaviour:
- Reset (rstn=0 at edge) has priority over everything; applies mid-frame too. After reset:
  - frame_data=0, frame_valid=0, fill_level=0, overflow=0, drop_cnt=0.
  - Fill FSM=FILLING.
  - All partial and held data are lost.
- Word order: first word of a frame goes to frame_data[FRAME_W-1 -: WORD_W]; last word goes to [WORD_W-1:0]. Big-endian word order, bytes [15..0].
- Fill FSM states:
  - FILLING: in_valid writes in_data at slot fill_level; fill_level++. When the write makes fill_level=WORDS_PER_FRAME:
    - if hold is empty, or being consumed this edge: frame transfers to hold at the next edge and fill_level returns to 0;
    - otherwise go to PENDING with fill_level=WORDS_PER_FRAME.
  - PENDING: the complete frame waits in the fill buffer. On a hold-consume edge it transfers to hold and the FSM returns to FILLING.
- Latency: the last word sampled at edge t gives frame_valid=1 and new frame_data visible after edge t+1. One register stage through the fill buffer; no combinational in->out path.
- Hold handshake:
  - Consume = frame_valid & frame_ready at an edge.
  - frame_ready while frame_valid=0 is ignored (no effect, no error).
  - After a consume with nothing to transfer, frame_valid goes 0 next cycle; frame_data retains its last value.
  - Consume plus a transfer at the same edge: frame_valid stays 1 and frame_data updates to the new frame.
- Word arriving while PENDING:
  - If a consume happens at the same edge, the word is accepted as slot 0 of the next frame (fill_level=1 after the edge).
  - Otherwise it is dropped: overflow<=1, drop_cnt<=drop_cnt+1 (saturating).
- Flush:
  - In FILLING: fill_level<=0 and partial data are discarded.
  - In PENDING: no effect.
  - Never touches hold.
  - flush with in_valid in FILLING: flush wins; the word is discarded and not counted as dropped.
- clr_overflow: clears overflow and drop_cnt. A drop at the same edge wins: overflow=1, drop_cnt=1.
- No X propagation: unused fill-buffer slots hold 0 after reset. Slots are not cleared between frames; every slot is overwritten before a frame transfers.

Decomposition:
- Shared package ok_frame_pkg holds:
  - WORD_W, WORDS_PER_FRAME, FRAME_W, LVL_W;
  - fill_state_t enum {FILLING, PENDING};
  - the DROP_CNT_W=16 constant.
- The adder-tree FSM also imports FRAME_W from this package.
- No sub-module: a single module of fill buffer, hold register, and status logic.

Test Plan:
1. Reset, then 4 words 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C on consecutive cycles -> frame_valid=1 one cycle after the 4th word; frame_data=0x03020100_07060504_0B0A0908_0F0E0D0C; fill_level 1,2,3,4→0.
2. Frame held (frame_ready=0), then 4 more words, then a 5th word -> fill_level=4 in PENDING; 5th word dropped, overflow=1, drop_cnt=1. Pulse frame_ready -> frame_valid stays 1 and frame_data switches to the second frame.
3. PENDING, with in_valid (0xAAAA5555) and frame_ready in the same cycle -> no drop; fill_level=1; the next completed frame's top word = 0xAAAA5555.
4. 2 words written, then flush, then 4 words 0x11111111..0x44444444 -> frame_data=0x11111111_22222222_33333333_44444444; the flushed words are absent; overflow=0.
5. rstn=0 for one cycle with 3 words in fill and a frame held -> all outputs 0 after the edge. The next 4 words form a clean frame.
6. Hold full, 0x10000 drops forced -> drop_cnt saturates at 0xFFFF. Then clr_overflow with a simultaneous drop -> overflow=1, drop_cnt=1.

Source files
------------

// File: rtl/ok_frame_pkg.sv
// Shared constants and types for the pipe-in frame path.
// Used by the frame assembler and by the downstream adder-tree FSM.
package ok_frame_pkg;

   localparam int WORD_W          = 32;
   localparam int WORDS_PER_FRAME = 4;
   localparam int FRAME_W         = WORD_W * WORDS_PER_FRAME;
   localparam int LVL_W           = $clog2(WORDS_PER_FRAME + 1);
   localparam int DROP_CNT_W      = 16;

   typedef enum logic {
      FILLING = 1'b0,
      PENDING = 1'b1
   } fill_state_t;

endpackage

// File: rtl/pipein_frame_assembler.sv
// Packs pipe-in words into frames, big-endian word order.
// Double-buffered: the fill buffer collects words while the hold register waits for the consumer.
module pipein_frame_assembler #(
   parameter  int WORD_W          = ok_frame_pkg::WORD_W,
   parameter  int WORDS_PER_FRAME = ok_frame_pkg::WORDS_PER_FRAME,
   localparam int FRAME_W         = WORD_W * WORDS_PER_FRAME,
   localparam int LVL_W           = $clog2(WORDS_PER_FRAME + 1)
) (
   input  logic                                okClk,
   input  logic                                rstn,
   input  logic [WORD_W-1:0]                   in_data,
   input  logic                                in_valid,
   input  logic                                flush,
   input  logic                                clr_overflow,
   input  logic                                frame_ready,
   output logic [FRAME_W-1:0]                  frame_data,
   output logic                                frame_valid,
   output logic [LVL_W-1:0]                    fill_level,
   output logic                                overflow,
   output logic [ok_frame_pkg::DROP_CNT_W-1:0] drop_cnt
);

   import ok_frame_pkg::fill_state_t;
   import ok_frame_pkg::FILLING;
   import ok_frame_pkg::PENDING;
   import ok_frame_pkg::DROP_CNT_W;

   localparam int                     SLOT_W   = (WORDS_PER_FRAME > 1) ? $clog2(WORDS_PER_FRAME) : 1;
   localparam logic [LVL_W-1:0]       LVL_FULL = LVL_W'(WORDS_PER_FRAME);
   localparam logic [DROP_CNT_W-1:0]  CNT_MAX  = '1;

   fill_state_t                             state, state_nxt;
   logic [WORDS_PER_FRAME-1:0][WORD_W-1:0]  fill_buf;
   logic [LVL_W-1:0]                        lvl, lvl_nxt, lvl_inc;
   logic [SLOT_W-1:0]                       wr_slot;
   logic [FRAME_W-1:0]                      frame_asm;
   logic                                    consume, full, xfer, wr_en, drop;

   assign fill_level = lvl;
   assign consume    = frame_valid & frame_ready;
   assign full       = (lvl == LVL_FULL);
   assign lvl_inc    = lvl + 1'b1;

   // Slot 0 lands in the top word of the frame.
   always_comb begin
      frame_asm = '0;
      for (int i = 0; i < WORDS_PER_FRAME; i++)
         frame_asm[FRAME_W-1-i*WORD_W -: WORD_W] = fill_buf[i];
   end

   always_comb begin
      state_nxt = state;
      lvl_nxt   = lvl;
      xfer      = 1'b0;
      wr_en     = 1'b0;
      wr_slot   = lvl[SLOT_W-1:0];
      drop      = 1'b0;
      case (state)
         FILLING: begin
            if (full) begin
               // Completed last edge with hold already free: move it now, and
               // a word arriving alongside starts the next frame.
               xfer    = 1'b1;
               lvl_nxt = '0;
               if (in_valid) begin
                  wr_en   = 1'b1;
                  wr_slot = '0;
                  lvl_nxt = LVL_W'(1);
               end
            end else if (flush) begin
               lvl_nxt = '0;
            end else if (in_valid) begin
               wr_en   = 1'b1;
               lvl_nxt = lvl_inc;
               if (lvl_inc == LVL_FULL && frame_valid && !consume)
                  state_nxt = PENDING;
            end
         end
         PENDING: begin
            if (consume) begin
               xfer      = 1'b1;
               state_nxt = FILLING;
               lvl_nxt   = '0;
               if (in_valid) begin
                  wr_en   = 1'b1;
                  wr_slot = '0;
                  lvl_nxt = LVL_W'(1);
               end
            end else if (in_valid) begin
               drop = 1'b1;
            end
         end
         default: state_nxt = FILLING;
      endcase
   end

   always_ff @(posedge okClk) begin
      if (!rstn) begin
         state       <= FILLING;
         lvl         <= '0;
         fill_buf    <= '0;
         frame_data  <= '0;
         frame_valid <= 1'b0;
         overflow    <= 1'b0;
         drop_cnt    <= '0;
      end else begin
         state <= state_nxt;
         lvl   <= lvl_nxt;
         if (wr_en)
            fill_buf[wr_slot] <= in_data;

         if (xfer) begin
            frame_data  <= frame_asm;
            frame_valid <= 1'b1;
         end else if (consume) begin
            frame_valid <= 1'b0;
         end

         // A drop on the clear edge restarts the count at one.
         if (drop) begin
            overflow <= 1'b1;
            if (clr_overflow)
               drop_cnt <= DROP_CNT_W'(1);
            else if (drop_cnt != CNT_MAX)
               drop_cnt <= drop_cnt + 1'b1;
         end else if (clr_overflow) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
         end
      end
   end

endmodule

// File: tb/tb_pipein_frame_assembler.sv
// Directed bench for pipein_frame_assembler: fill, hold, drop, flush, reset and saturation.
module tb_pipein_frame_assembler;

   logic          okClk = 1'b0;
   logic          rstn = 1'b0;
   logic [31:0]   in_data = '0;
   logic          in_valid = 1'b0;
   logic          flush = 1'b0;
   logic          clr_overflow = 1'b0;
   logic          frame_ready = 1'b0;
   logic [127:0]  frame_data;
   logic          frame_valid;
   logic [2:0]    fill_level;
   logic          overflow;
   logic [15:0]   drop_cnt;

   int total = 0;
   int bad   = 0;

   pipein_frame_assembler dut (
      .okClk        (okClk),
      .rstn         (rstn),
      .in_data      (in_data),
      .in_valid     (in_valid),
      .flush        (flush),
      .clr_overflow (clr_overflow),
      .frame_ready  (frame_ready),
      .frame_data   (frame_data),
      .frame_valid  (frame_valid),
      .fill_level   (fill_level),
      .overflow     (overflow),
      .drop_cnt     (drop_cnt)
   );

   always #5 okClk = ~okClk;

   task automatic tick();
      @(posedge okClk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [31:0] w);
      in_valid = 1'b1;
      in_data  = w;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic wr4(input logic [31:0] a, b, c, d);
      wr(a); wr(b); wr(c); wr(d);
   endtask

   initial begin
      // Reset
      tick(); tick();
      chk("rst_data",  frame_data, 128'h0);
      chk("rst_valid", 128'(frame_valid), 128'h0);
      chk("rst_lvl",   128'(fill_level), 128'h0);
      chk("rst_ovf",   128'(overflow), 128'h0);
      chk("rst_drop",  128'(drop_cnt), 128'h0);
      rstn = 1'b1;

      // 1: first frame, one cycle of staging before hold
      wr(32'h03020100); chk("t1_lvl1", 128'(fill_level), 128'd1);
      wr(32'h07060504); chk("t1_lvl2", 128'(fill_level), 128'd2);
      wr(32'h0B0A0908); chk("t1_lvl3", 128'(fill_level), 128'd3);
      wr(32'h0F0E0D0C); chk("t1_lvl4", 128'(fill_level), 128'd4);
      chk("t1_valid_early", 128'(frame_valid), 128'h0);
      tick();
      chk("t1_valid", 128'(frame_valid), 128'h1);
      chk("t1_data",  frame_data, 128'h03020100_07060504_0B0A0908_0F0E0D0C);
      chk("t1_lvl0",  128'(fill_level), 128'd0);

      // 2: second frame pends behind the held one, fifth word dropped
      wr4(32'h10000001, 32'h10000002, 32'h10000003, 32'h10000004);
      tick();
      chk("t2_lvl_pend", 128'(fill_level), 128'd4);
      chk("t2_data_old", frame_data, 128'h03020100_07060504_0B0A0908_0F0E0D0C);
      wr(32'hDEADBEEF);
      chk("t2_ovf",  128'(overflow), 128'h1);
      chk("t2_drop", 128'(drop_cnt), 128'd1);
      chk("t2_lvl",  128'(fill_level), 128'd4);
      frame_ready = 1'b1; tick(); frame_ready = 1'b0;
      chk("t2_valid", 128'(frame_valid), 128'h1);
      chk("t2_data",  frame_data, 128'h10000001_10000002_10000003_10000004);
      chk("t2_lvl0",  128'(fill_level), 128'd0);

      // 3: word plus consume while pending is kept as slot 0
      wr4(32'h20000001, 32'h20000002, 32'h20000003, 32'h20000004);
      chk("t3_lvl_pend", 128'(fill_level), 128'd4);
      frame_ready = 1'b1; wr(32'hAAAA5555); frame_ready = 1'b0;
      chk("t3_lvl1", 128'(fill_level), 128'd1);
      chk("t3_drop", 128'(drop_cnt), 128'd1);
      chk("t3_data", frame_data, 128'h20000001_20000002_20000003_20000004);
      wr(32'hB1B1B1B1); wr(32'hB2B2B2B2); wr(32'hB3B3B3B3);
      frame_ready = 1'b1; tick(); frame_ready = 1'b0;
      chk("t3_data2", frame_data, 128'hAAAA5555_B1B1B1B1_B2B2B2B2_B3B3B3B3);
      clr_overflow = 1'b1; tick(); clr_overflow = 1'b0;
      chk("t3_clr_ovf",  128'(overflow), 128'h0);
      chk("t3_clr_drop", 128'(drop_cnt), 128'd0);
      frame_ready = 1'b1; tick(); frame_ready = 1'b0;
      chk("t3_drain_valid", 128'(frame_valid), 128'h0);
      chk("t3_drain_data",  frame_data, 128'hAAAA5555_B1B1B1B1_B2B2B2B2_B3B3B3B3);
      frame_ready = 1'b1; tick(); frame_ready = 1'b0;
      chk("t3_idle_ready", 128'(frame_valid), 128'h0);

      // 4: flush discards partial words; a concurrent word is not a drop
      wr(32'h55555555); wr(32'h66666666);
      chk("t4_lvl2", 128'(fill_level), 128'd2);
      flush = 1'b1; wr(32'h77777777); flush = 1'b0;
      chk("t4_lvl0", 128'(fill_level), 128'd0);
      chk("t4_ovf",  128'(overflow), 128'h0);
      wr4(32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444);
      tick();
      chk("t4_valid", 128'(frame_valid), 128'h1);
      chk("t4_data",  frame_data, 128'h11111111_22222222_33333333_44444444);
      chk("t4_drop",  128'(drop_cnt), 128'd0);

      // 5: reset mid-frame with a held frame
      wr(32'h0000C0C0); wr(32'h0000C1C1); wr(32'h0000C2C2);
      chk("t5_lvl3", 128'(fill_level), 128'd3);
      rstn = 1'b0; tick(); rstn = 1'b1;
      chk("t5_data",  frame_data, 128'h0);
      chk("t5_valid", 128'(frame_valid), 128'h0);
      chk("t5_lvl",   128'(fill_level), 128'd0);
      wr4(32'hC1000001, 32'hC1000002, 32'hC1000003, 32'hC1000004);
      tick();
      chk("t5_frame", frame_data, 128'hC1000001_C1000002_C1000003_C1000004);

      // 6: drop counter saturation, then clear racing a drop
      wr4(32'hD0000001, 32'hD0000002, 32'hD0000003, 32'hD0000004);
      chk("t6_lvl_pend", 128'(fill_level), 128'd4);
      in_valid = 1'b1; in_data = 32'hEEEEEEEE;
      repeat (65536) tick();
      chk("t6_sat",     128'(drop_cnt), 128'hFFFF);
      chk("t6_sat_ovf", 128'(overflow), 128'h1);
      clr_overflow = 1'b1; tick(); clr_overflow = 1'b0; in_valid = 1'b0;
      chk("t6_clr_ovf",  128'(overflow), 128'h1);
      chk("t6_clr_drop", 128'(drop_cnt), 128'd1);
      chk("t6_held",     frame_data, 128'hC1000001_C1000002_C1000003_C1000004);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
